// File: rtl/branch_target_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer_pkg
//  Description : Shared helpers for the branch target buffer: direction
//                counter encodings derived from the counter width, and PC
//                index/tag field extraction.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_target_buffer_pkg;

  // Weakly-taken: MSB set, all other bits clear (2'b10 for a 2-bit counter).
  function automatic int unsigned weak_t(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

  // Weakly-not-taken: one below weakly-taken (2'b01 for a 2-bit counter).
  function automatic int unsigned weak_nt(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  // Saturation ceiling: all ones.
  function automatic int unsigned sat_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  // Index field: the INDEX_W bits just above the dropped offset bits.
  function automatic logic [63:0] pc_index(input logic [63:0] pc,
                                           input int unsigned off_w,
                                           input int unsigned index_w);
    return (pc >> off_w) & ((64'd1 << index_w) - 64'd1);
  endfunction

  // Tag field: everything above the index field.
  function automatic logic [63:0] pc_tag(input logic [63:0] pc,
                                         input int unsigned off_w,
                                         input int unsigned index_w);
    return pc >> (off_w + index_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer_if
//  Description : Lookup / update / status bundle between the pipeline and
//                the branch target buffer.
//                master : IF + resolve stage (drives lookup, update, flush)
//                slave  : the BTB (returns prediction and mispredict status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_target_buffer_if #(
  parameter int ADDR_W = 16,
  parameter int STAT_W = 16
);
  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              flush;
  logic              mispredict;
  logic [STAT_W-1:0] mispred_count;

  modport master (
    output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
    input  pred_taken, pred_pc, mispredict, mispred_count
  );

  modport slave (
    input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
    output pred_taken, pred_pc, mispredict, mispred_count
  );
endinterface
`default_nettype wire

// File: rtl/branch_target_buffer_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer_sat_counter
//  Description : Next-value logic for a saturating direction counter.
//                Ports: cur (present value), inc, dec, load, load_val,
//                nxt (next value). load has priority over inc/dec.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer_sat_counter
  import branch_target_buffer_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  wire logic [CNT_W-1:0] cur,
  input  wire logic             inc,
  input  wire logic             dec,
  input  wire logic             load,
  input  wire logic [CNT_W-1:0] load_val,
  output logic      [CNT_W-1:0] nxt
);
  localparam logic [CNT_W-1:0] SAT_MAX = CNT_W'(sat_max(CNT_W));

  always_comb begin
    nxt = cur;
    if (load) begin
      nxt = load_val;
    end else if (inc && (cur != SAT_MAX)) begin
      nxt = cur + 1'b1;
    end else if (dec && (cur != '0)) begin
      nxt = cur - 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer
//  Description : Tagged, direct-mapped BTB with a saturating direction
//                counter per entry.
//                clk, rst : clock / synchronous active-high reset
//                bus      : slave side of branch_target_buffer_if
//                  lookup_valid/lookup_pc -> pred_taken/pred_pc (same cycle)
//                  upd_*  : resolved branch outcome, written at posedge
//                  flush  : invalidate all entries
//                  mispredict/mispred_count : registered status
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 4,
  parameter int OFF_W   = 2,
  parameter int PC_INC  = 4,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input wire logic clk,
  input wire logic rst,
  branch_target_buffer_if.slave bus
);
  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = ADDR_W - OFF_W - INDEX_W;
  localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(weak_t(CNT_W));
  localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(weak_nt(CNT_W));

  generate
    if (OFF_W + INDEX_W >= ADDR_W) begin : g_bad_fields
      $error("branch_target_buffer: OFF_W+INDEX_W must be below ADDR_W");
    end
    if (CNT_W < 2) begin : g_bad_cnt
      $error("branch_target_buffer: CNT_W must be at least 2");
    end
  endgenerate

  logic              valid_arr [ENTRIES];
  logic [TAG_W-1:0]  tag_arr   [ENTRIES];
  logic [ADDR_W-1:0] tgt_arr   [ENTRIES];
  logic [CNT_W-1:0]  cnt_arr   [ENTRIES];
  logic              mis_q;
  logic [STAT_W-1:0] stat_q;

  // Lookup read port
  logic [INDEX_W-1:0] l_idx;
  logic [TAG_W-1:0]   l_tag;
  logic               l_hit;
  assign l_idx = INDEX_W'(pc_index(64'(bus.lookup_pc), OFF_W, INDEX_W));
  assign l_tag = TAG_W'(pc_tag(64'(bus.lookup_pc), OFF_W, INDEX_W));
  assign l_hit = valid_arr[l_idx] && (tag_arr[l_idx] == l_tag);

  assign bus.pred_taken = bus.lookup_valid && l_hit && cnt_arr[l_idx][CNT_W-1];
  assign bus.pred_pc    = bus.pred_taken ? tgt_arr[l_idx]
                                         : bus.lookup_pc + ADDR_W'(PC_INC);

  // Update read port: judges the prediction this entry would have given
  logic [INDEX_W-1:0] u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_hit;
  logic               u_old_pred;
  logic               u_mis;
  logic               u_we;
  logic [CNT_W-1:0]   u_cnt_nxt;
  assign u_idx      = INDEX_W'(pc_index(64'(bus.upd_pc), OFF_W, INDEX_W));
  assign u_tag      = TAG_W'(pc_tag(64'(bus.upd_pc), OFF_W, INDEX_W));
  assign u_hit      = valid_arr[u_idx] && (tag_arr[u_idx] == u_tag);
  assign u_old_pred = u_hit && cnt_arr[u_idx][CNT_W-1];
  assign u_mis      = (bus.upd_taken != u_old_pred) ||
                      (bus.upd_taken && u_old_pred && (tgt_arr[u_idx] != bus.upd_target));
  // A not-taken branch that misses is never allocated.
  assign u_we       = bus.upd_valid && !bus.flush && (u_hit || bus.upd_taken);

  branch_target_buffer_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .cur      (cnt_arr[u_idx]),
    .inc      (u_hit && bus.upd_taken),
    .dec      (u_hit && !bus.upd_taken),
    .load     (!u_hit && bus.upd_taken),
    .load_val (WEAK_T),
    .nxt      (u_cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_arr[i] <= 1'b0;
        tag_arr[i]   <= '0;
        tgt_arr[i]   <= '0;
        cnt_arr[i]   <= WEAK_NT;
      end
      mis_q  <= 1'b0;
      stat_q <= '0;
    end else begin
      if (bus.flush) begin
        for (int i = 0; i < ENTRIES; i++) begin
          valid_arr[i] <= 1'b0;
        end
      end else if (u_we) begin
        valid_arr[u_idx] <= 1'b1;
        tag_arr[u_idx]   <= u_tag;
        cnt_arr[u_idx]   <= u_cnt_nxt;
        if (bus.upd_taken) begin
          tgt_arr[u_idx] <= bus.upd_target;
        end
      end
      // Mispredict status is still reported for an update dropped by flush.
      mis_q <= bus.upd_valid && u_mis;
      if (bus.upd_valid && u_mis && (stat_q != '1)) begin
        stat_q <= stat_q + 1'b1;
      end
    end
  end

  assign bus.mispredict    = mis_q;
  assign bus.mispred_count = stat_q;
endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_target_buffer
//  Description : Self-checking bench for branch_target_buffer (STAT_W=4
//                build so counter saturation is reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;
  localparam int STAT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_target_buffer_if #(.ADDR_W(16), .STAT_W(STAT_W)) bus ();

  branch_target_buffer #(
    .ADDR_W(16), .INDEX_W(4), .OFF_W(2), .PC_INC(4), .CNT_W(2), .STAT_W(STAT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: 16 entries, counter as 0..3 ----------
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int unsigned m_ctr   [16];
  bit          m_mis;
  int unsigned m_stat;

  function automatic int unsigned midx(input int unsigned pc);
    return (pc / 4) % 16;
  endfunction
  function automatic int unsigned mtag(input int unsigned pc);
    return pc / 64;
  endfunction

  always @(posedge clk) begin
    int unsigned i;
    bit hit, oldp, mis;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
      end
      m_mis  = 0;
      m_stat = 0;
    end else begin
      i    = midx(bus.upd_pc);
      hit  = m_valid[i] && (m_tag[i] == mtag(bus.upd_pc));
      oldp = hit && (m_ctr[i] >= 2);
      mis  = (bus.upd_taken != oldp) || (bus.upd_taken && oldp && m_tgt[i] != bus.upd_target);
      m_mis = bus.upd_valid && mis;
      if (m_mis && m_stat < (1 << STAT_W) - 1) m_stat++;
      if (bus.flush) begin
        for (int k = 0; k < 16; k++) m_valid[k] = 0;
      end else if (bus.upd_valid) begin
        if (hit) begin
          if (bus.upd_taken) begin
            if (m_ctr[i] < 3) m_ctr[i]++;
            m_tgt[i] = bus.upd_target;
          end else if (m_ctr[i] > 0) begin
            m_ctr[i]--;
          end
        end else if (bus.upd_taken) begin
          m_valid[i] = 1; m_tag[i] = mtag(bus.upd_pc);
          m_tgt[i] = bus.upd_target; m_ctr[i] = 2;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ------------------
  always @(negedge clk) begin
    int unsigned i, exp_pc;
    bit pt;
    if (chk_en) begin
      i  = midx(bus.lookup_pc);
      pt = bus.lookup_valid && m_valid[i] && m_tag[i] == mtag(bus.lookup_pc) && m_ctr[i] >= 2;
      exp_pc = pt ? m_tgt[i] : (bus.lookup_pc + 4) % 65536;
      chk("pred_taken", 32'(bus.pred_taken), 32'(pt));
      chk("pred_pc", 32'(bus.pred_pc), exp_pc);
      chk("mispredict", 32'(bus.mispredict), 32'(m_mis));
      chk("mispred_count", 32'(bus.mispred_count), m_stat);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [15:0] lpc);
    bus.lookup_valid = 1'b1; bus.lookup_pc = lpc;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;
    bus.flush = 1'b0;
  endtask

  task automatic upd(input logic [15:0] pc, input bit taken, input logic [15:0] tgt);
    bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_taken = taken; bus.upd_target = tgt;
  endtask

  // Drive an update for one edge, then return to idle with a lookup.
  task automatic do_upd(input logic [15:0] pc, input bit taken, input logic [15:0] tgt,
                        input logic [15:0] lpc);
    upd(pc, taken, tgt);
    step();
    idle(lpc);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle(16'h0010);
    repeat (2) step();
    chk_en = 1'b1;
    rst = 1'b0;
    #1;
    // 1: reset state
    chk("t1_pred_taken", 32'(bus.pred_taken), 32'd0);
    chk("t1_pred_pc", 32'(bus.pred_pc), 32'h0014);
    chk("t1_mispredict", 32'(bus.mispredict), 32'd0);
    chk("t1_count", 32'(bus.mispred_count), 32'd0);

    // 2: first allocation
    do_upd(16'h0010, 1'b1, 16'h0100, 16'h0010);
    chk("t2_mispredict", 32'(bus.mispredict), 32'd1);
    chk("t2_count", 32'(bus.mispred_count), 32'd1);
    chk("t2_pred_pc", 32'(bus.pred_pc), 32'h0100);
    step();
    chk("t2_pulse_end", 32'(bus.mispredict), 32'd0);

    // 3: alias replaces the entry at index 4
    do_upd(16'h0050, 1'b1, 16'h0200, 16'h0010);
    chk("t3_alias_miss", 32'(bus.pred_pc), 32'h0014);
    bus.lookup_pc = 16'h0050; #1;
    chk("t3_new_hit", 32'(bus.pred_pc), 32'h0200);

    // 4: hysteresis
    do_upd(16'h0010, 1'b1, 16'h0100, 16'h0010);
    do_upd(16'h0010, 1'b1, 16'h0100, 16'h0010);
    chk("t4_taken2_nomis", 32'(bus.mispredict), 32'd0);
    do_upd(16'h0010, 1'b0, 16'h0000, 16'h0010);
    chk("t4_nt1_mis", 32'(bus.mispredict), 32'd1);
    chk("t4_nt1_still_taken", 32'(bus.pred_pc), 32'h0100);
    do_upd(16'h0010, 1'b0, 16'h0000, 16'h0010);
    chk("t4_nt2_fallthru", 32'(bus.pred_pc), 32'h0014);
    chk("t4_count", 32'(bus.mispred_count), 32'd5);

    // 5: flush beats a same-cycle update
    bus.flush = 1'b1;
    do_upd(16'h0020, 1'b1, 16'h0300, 16'h0020);
    chk("t5_mispredict", 32'(bus.mispredict), 32'd1);
    chk("t5_no_alloc", 32'(bus.pred_pc), 32'h0024);
    bus.lookup_pc = 16'h0050; #1;
    chk("t5_flushed", 32'(bus.pred_pc), 32'h0054);
    bus.lookup_pc = 16'hFFFC; #1;
    chk("t5_wrap", 32'(bus.pred_pc), 32'h0000);

    // Randomised traffic over a small PC pool so entries hit and alias.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      bus.lookup_valid = ($urandom_range(0, 7) != 0);
      bus.lookup_pc    = 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      if ($urandom_range(0, 9) == 0) bus.lookup_pc = 16'($urandom);
      bus.upd_valid  = ($urandom_range(0, 2) != 0);
      bus.upd_pc     = 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      bus.upd_taken  = ($urandom_range(0, 2) != 0);
      bus.upd_target = 16'($urandom_range(0, 3) << 8);
      bus.flush      = ($urandom_range(0, 39) == 0);
    end

    // 6: saturation, then reset alongside an update
    idle(16'h0010);
    rst = 1'b1; step(); rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      bus.flush = 1'b1;
      upd(16'h0040, 1'b1, 16'h0400);
      step();
    end
    idle(16'h0010);
    #1;
    chk("t6_saturated", 32'(bus.mispred_count), 32'hF);
    rst = 1'b1;
    do_upd(16'h0010, 1'b1, 16'h0100, 16'h0010);
    rst = 1'b0;
    chk("t6_rst_count", 32'(bus.mispred_count), 32'd0);
    chk("t6_rst_mis", 32'(bus.mispredict), 32'd0);
    chk("t6_rst_no_write", 32'(bus.pred_pc), 32'h0014);
    step();
    step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
`default_nettype wire
